// File: rtl/p2s_chain.sv
// p2s_chain: parallel-to-serial driver for daisy-chained SIPO shift registers.
// Captures a CHANNELS*BIT_WIDTH frame on start, shifts it out on sout with a
// divided serial clock, pulses EN to latch the chain, then pulses finish.
//
// Handshake: start is a request that is only honoured in IDLE; once taken,
// busy stays high through SHIFT and LATCH, and finish pulses for exactly one
// cycle (busy low) before the block returns to IDLE and can accept again.
// There is no back-pressure and no queueing of requests made while busy.
module p2s_chain #(
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 2,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BIT_WIDTH*CHANNELS-1:0]   par_in,
    output logic                            sclk,
    output logic                            sclrn,
    output logic                            sout,
    output logic                            EN,
    output logic                            busy,
    output logic                            finish,
    output logic [1:0]                      o_dbg_state
);

    localparam int N  = BIT_WIDTH * CHANNELS;
    localparam int BW = $clog2(N + 1);
    localparam int DW = $clog2(DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state, w_state_nx;
    logic [N-1:0]   r_sh, w_sh_nx;
    logic [BW-1:0]  r_bit, w_bit_nx;
    logic [DW-1:0]  r_div, w_div_nx;
    logic           r_sclk, w_sclk_nx;
    logic           r_sout, w_sout_nx;
    logic           r_en, w_en_nx;
    logic           r_busy, w_busy_nx;
    logic           r_finish, w_finish_nx;
    logic           r_sclrn;

    logic [N-1:0]   w_sh_adv;
    logic           w_first_cap;
    logic           w_first_adv;
    logic           w_div_last;

    // Shifted frame and the bit that becomes current, for either bit order
    always_comb begin
        w_sh_adv    = (MSB_FIRST != 0) ? (r_sh << 1) : (r_sh >> 1);
        w_first_cap = (MSB_FIRST != 0) ? par_in[N-1] : par_in[0];
        w_first_adv = (MSB_FIRST != 0) ? w_sh_adv[N-1] : w_sh_adv[0];
        w_div_last  = (r_div == DIV_LAST);
    end

    // Next-state and next-output logic; every register holds unless told otherwise
    always_comb begin
        w_state_nx  = r_state;
        w_sh_nx     = r_sh;
        w_bit_nx    = r_bit;
        w_div_nx    = r_div;
        w_sclk_nx   = r_sclk;
        w_sout_nx   = r_sout;
        w_en_nx     = r_en;
        w_busy_nx   = r_busy;
        w_finish_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_SHIFT;
                    w_sh_nx    = par_in;
                    w_bit_nx   = '0;
                    w_div_nx   = '0;
                    w_sclk_nx  = 1'b0;
                    w_sout_nx  = w_first_cap;
                    w_busy_nx  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_last) begin
                    w_div_nx = '0;
                    if (!r_sclk) begin
                        // end of low half: raise sclk with data already stable
                        w_sclk_nx = 1'b1;
                    end else if (r_bit == BIT_LAST) begin
                        w_state_nx = S_LATCH;
                        w_sclk_nx  = 1'b0;
                        w_sout_nx  = 1'b0;
                        w_en_nx    = 1'b1;
                    end else begin
                        // end of high half: next bit changes together with sclk falling
                        w_bit_nx  = r_bit + BW'(1);
                        w_sclk_nx = 1'b0;
                        w_sh_nx   = w_sh_adv;
                        w_sout_nx = w_first_adv;
                    end
                end else begin
                    w_div_nx = r_div + DW'(1);
                end
            end
            S_LATCH: begin
                if (w_div_last) begin
                    w_div_nx    = '0;
                    w_state_nx  = S_DONE;
                    w_en_nx     = 1'b0;
                    w_busy_nx   = 1'b0;
                    w_finish_nx = 1'b1;
                end else begin
                    w_div_nx = r_div + DW'(1);
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the partial frame immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sh     <= '0;
            r_bit    <= '0;
            r_div    <= '0;
            r_sclk   <= 1'b0;
            r_sout   <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_sh     <= w_sh_nx;
            r_bit    <= w_bit_nx;
            r_div    <= w_div_nx;
            r_sclk   <= w_sclk_nx;
            r_sout   <= w_sout_nx;
            r_en     <= w_en_nx;
            r_busy   <= w_busy_nx;
            r_finish <= w_finish_nx;
        end
    end

    // Chain clear: held low during reset, released on the first edge after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclrn <= 1'b0;
        end else begin
            r_sclrn <= 1'b1;
        end
    end

    assign sclk        = r_sclk;
    assign sclrn       = r_sclrn;
    assign sout        = r_sout;
    assign EN          = r_en;
    assign busy        = r_busy;
    assign finish      = r_finish;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_p2s_chain.sv
// Directed bench for p2s_chain: three instances (MSB-first, LSB-first and a
// minimum DIV=1 single-device chain) share clock and reset; one is observed
// at a time through a small output mux.
module tb_p2s_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [15:0] par_v;
    int          sel;

    logic a_sclk, a_sclrn, a_sout, a_en, a_busy, a_finish;
    logic b_sclk, b_sclrn, b_sout, b_en, b_busy, b_finish;
    logic c_sclk, c_sclrn, c_sout, c_en, c_busy, c_finish;
    logic [1:0] a_st, b_st, c_st;

    logic obs_sclk, obs_sclrn, obs_sout, obs_en, obs_busy, obs_finish;
    logic [1:0] obs_st;

    int n_chk = 0;
    int n_err = 0;
    bit aborted;

    // clock / reset block
    always #5 clk = ~clk;

    p2s_chain #(.BIT_WIDTH(8), .CHANNELS(2), .DIV(2), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .start(start_v[0]), .par_in(par_v),
        .sclk(a_sclk), .sclrn(a_sclrn), .sout(a_sout), .EN(a_en),
        .busy(a_busy), .finish(a_finish), .o_dbg_state(a_st));

    p2s_chain #(.BIT_WIDTH(8), .CHANNELS(2), .DIV(2), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .start(start_v[1]), .par_in(par_v),
        .sclk(b_sclk), .sclrn(b_sclrn), .sout(b_sout), .EN(b_en),
        .busy(b_busy), .finish(b_finish), .o_dbg_state(b_st));

    p2s_chain #(.BIT_WIDTH(8), .CHANNELS(1), .DIV(1), .MSB_FIRST(1)) u_min (
        .clk(clk), .rst(rst), .start(start_v[2]), .par_in(par_v[7:0]),
        .sclk(c_sclk), .sclrn(c_sclrn), .sout(c_sout), .EN(c_en),
        .busy(c_busy), .finish(c_finish), .o_dbg_state(c_st));

    always_comb begin
        obs_sclk = a_sclk; obs_sclrn = a_sclrn; obs_sout = a_sout;
        obs_en = a_en; obs_busy = a_busy; obs_finish = a_finish; obs_st = a_st;
        case (sel)
            1: begin
                obs_sclk = b_sclk; obs_sclrn = b_sclrn; obs_sout = b_sout;
                obs_en = b_en; obs_busy = b_busy; obs_finish = b_finish; obs_st = b_st;
            end
            2: begin
                obs_sclk = c_sclk; obs_sclrn = c_sclrn; obs_sout = c_sout;
                obs_en = c_en; obs_busy = c_busy; obs_finish = c_finish; obs_st = c_st;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (dut %0d cycle %0d): observed=%b expected=%b", tag, sel, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (dut %0d): observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    // All outputs of the observed instance at their reset values
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sclk"},   0, obs_sclk,   1'b0);
        chk({tag, "_sclrn"},  0, obs_sclrn,  1'b0);
        chk({tag, "_sout"},   0, obs_sout,   1'b0);
        chk({tag, "_en"},     0, obs_en,     1'b0);
        chk({tag, "_busy"},   0, obs_busy,   1'b0);
        chk({tag, "_finish"}, 0, obs_finish, 1'b0);
        chk_int({tag, "_state"}, int'(obs_st), 0);
    endtask

    // Driver: request a frame on instance s and check every cycle against the
    // timing formulas; seq holds the expected serial bits, first-sent leftmost.
    task automatic run_frame(input int s, input int div, input int n, input logic [15:0] seq,
                             input bit hold, input bit mod10, input int rst_at, output bit ab);
        int sh;
        int total;
        int edges;
        logic [15:0] got;
        logic prev;
        sh    = 2 * div * n;
        total = sh + div + 1;
        edges = 0;
        got   = '0;
        prev  = 1'b0;
        ab    = 1'b0;
        sel   = s;
        start_v[s] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (!hold) start_v[s] = 1'b0;
            if (mod10 && c == 10) par_v = 16'hFFFF;
            if (c == rst_at) begin
                ab = 1'b1;
                return;
            end
            chk("busy",   c, obs_busy,   c <= sh + div);
            chk("en",     c, obs_en,     (c > sh) && (c <= sh + div));
            chk("finish", c, obs_finish, c == total);
            chk("sclk",   c, obs_sclk,   (c <= sh) && (((c - 1) % (2 * div)) >= div));
            chk("sclrn",  c, obs_sclrn,  1'b1);
            if (c <= sh) chk("sout", c, obs_sout, seq[n - 1 - (c - 1) / (2 * div)]);
            if (c == total) chk("sout_done", c, obs_sout, 1'b0);
            if (obs_sclk && !prev) begin
                got = {got[14:0], obs_sout};
                edges++;
            end
            prev = obs_sclk;
        end
        chk_int("sclk_edges", edges, n);
        chk_int("frame", int'(got), int'(seq));
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        par_v   = '0;
        sel     = 0;

        // reset state of all three instances
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0 chk_reset_vals("reset");
        end
        rst = 1'b0;
        sel = 0;
        #1 chk("sclrn_before_edge", 0, obs_sclrn, 1'b0);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0 chk("sclrn_released", 0, obs_sclrn, 1'b1);
        end

        // basic MSB-first frame
        par_v = 16'hA5C3;
        run_frame(0, 2, 16, 16'b1010010111000011, 1'b0, 1'b0, 0, aborted);
        repeat (3) @(negedge clk);

        // LSB-first frame
        run_frame(1, 2, 16, 16'b1100001110100101, 1'b0, 1'b0, 0, aborted);
        repeat (3) @(negedge clk);

        // start held and par_in changed mid-frame
        par_v = 16'hA5C3;
        run_frame(0, 2, 16, 16'b1010010111000011, 1'b1, 1'b1, 0, aborted);
        @(negedge clk);
        chk("busy_after_done", 68, obs_busy, 1'b0);
        chk("finish_after_done", 68, obs_finish, 1'b0);
        run_frame(0, 2, 16, 16'hFFFF, 1'b0, 1'b0, 0, aborted);
        repeat (3) @(negedge clk);

        // reset mid-frame
        par_v = 16'hA5C3;
        run_frame(0, 2, 16, 16'b1010010111000011, 1'b0, 1'b0, 30, aborted);
        chk("aborted", 30, aborted, 1'b1);
        rst = 1'b1;
        #1 chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("sclrn_held", 0, obs_sclrn, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_en_after_rst", i, obs_en, 1'b0);
            chk("idle_after_rst", i, obs_busy, 1'b0);
            chk("sclrn_after_rst", i, obs_sclrn, 1'b1);
        end
        run_frame(0, 2, 16, 16'b1010010111000011, 1'b0, 1'b0, 0, aborted);
        repeat (3) @(negedge clk);

        // minimum configuration, start held across two frames
        par_v = 16'h0081;
        run_frame(2, 1, 8, 16'h0081, 1'b1, 1'b0, 0, aborted);
        @(negedge clk);
        chk("min_idle_busy", 19, obs_busy, 1'b0);
        chk("min_idle_finish", 19, obs_finish, 1'b0);
        run_frame(2, 1, 8, 16'h0081, 1'b0, 1'b0, 0, aborted);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
